div_unit_pipe_ctrl: RTL and testbench

- Parametrised, multi-cycle, radix-2 non-restoring integer divider for the M-extension execute stage. Successor to the fixed 32-bit divider.
- Adds valid/ready handshakes on input and output, full RISC-V corner-case semantics (divide-by-zero, signed overflow) and a kill/flush input.
- One divider instance sits beside the multiplier; the issue logic uses fu_state_o to stall on it.

---
 rtl/div_unit_pipe_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_div_unit_pipe_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_pipe_ctrl
// Brief    : Radix-2 non-restoring XLEN-bit integer divider with valid/ready
//            handshakes. Optional macro DIV_EARLY_TERM_EN adds a one-cycle
//            finish when |dividend| < |divisor|.
// Revision : 1.0 - initial release
// ============================================================================

package div_unit_pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        DIV_  = 2'd0,
        DIVU_ = 2'd1,
        REM_  = 2'd2,
        REMU_ = 2'd3
    } div_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;
endpackage

module div_unit_pipe_ctrl
    import div_unit_pipe_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clk_en_i,
    input  logic            kill_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  div_ops_e        operation_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_divide_o,
    output fu_state_e       fu_state_o
);

    localparam int               CNT_W       = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_int_min   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVIDE  = 2'd1,
        S_RESTORE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e           r_state,  w_state_nxt;
    logic [XLEN:0]    r_p,      w_p_nxt;
    logic [XLEN-1:0]  r_a,      w_a_nxt;
    logic [XLEN-1:0]  r_b,      w_b_nxt;
    logic [XLEN-1:0]  r_result, w_result_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic             r_rem,    w_rem_nxt;
    logic             r_neg_q,  w_neg_q_nxt;
    logic             r_neg_r,  w_neg_r_nxt;
    logic             r_zdiv,   w_zdiv_nxt;

    logic             w_signed, w_is_rem, w_a_neg, w_b_neg;
    logic             w_div_zero, w_ovf, w_early;
    logic [XLEN-1:0]  w_a_mag, w_b_mag;
    logic [XLEN:0]    w_p_sh, w_p_iter, w_p_fix;
    logic [XLEN-1:0]  w_rem_mag, w_q_final, w_r_final;

    // Operand decode, only consumed on the accept edge
    assign w_signed   = (operation_i == DIV_) || (operation_i == REM_);
    assign w_is_rem   = (operation_i == REM_) || (operation_i == REMU_);
    assign w_a_neg    = w_signed & dividend_i[XLEN-1];
    assign w_b_neg    = w_signed & divisor_i[XLEN-1];
    assign w_a_mag    = w_a_neg ? -dividend_i : dividend_i;
    assign w_b_mag    = w_b_neg ? -divisor_i  : divisor_i;
    assign w_div_zero = (divisor_i == '0);
    assign w_ovf      = w_signed && (dividend_i == c_int_min) && (divisor_i == '1);

`ifdef DIV_EARLY_TERM_EN
    assign w_early = !w_div_zero && !w_ovf && (w_a_mag < w_b_mag);
`else
    assign w_early = 1'b0;
`endif

    // P is kept modulo 2^(XLEN+1); its true value always lies in [-B, B)
    assign w_p_sh    = {r_p[XLEN-1:0], r_a[XLEN-1]};
    assign w_p_iter  = r_p[XLEN] ? (w_p_sh + {1'b0, r_b}) : (w_p_sh - {1'b0, r_b});
    assign w_p_fix   = r_p[XLEN] ? (r_p + {1'b0, r_b}) : r_p;
    assign w_rem_mag = w_p_fix[XLEN-1:0];
    assign w_q_final = r_neg_q ? -r_a : r_a;
    assign w_r_final = r_neg_r ? -w_rem_mag : w_rem_mag;

    always_comb begin
        w_state_nxt  = r_state;
        w_p_nxt      = r_p;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_result_nxt = r_result;
        w_cnt_nxt    = r_cnt;
        w_rem_nxt    = r_rem;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_zdiv_nxt   = r_zdiv;

        if (clk_en_i) begin
            if (kill_i) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_zdiv_nxt  = 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (valid_i) begin
                            w_p_nxt     = '0;
                            w_a_nxt     = w_a_mag;
                            w_b_nxt     = w_b_mag;
                            w_cnt_nxt   = '0;
                            w_rem_nxt   = w_is_rem;
                            w_neg_q_nxt = w_a_neg ^ w_b_neg;
                            w_neg_r_nxt = w_a_neg;
                            w_zdiv_nxt  = w_div_zero;
                            if (w_div_zero) begin
                                w_result_nxt = w_is_rem ? dividend_i : '1;
                                w_state_nxt  = S_DONE;
                            end else if (w_ovf) begin
                                w_result_nxt = w_is_rem ? '0 : c_int_min;
                                w_state_nxt  = S_DONE;
                            end else if (w_early) begin
                                w_result_nxt = w_is_rem ? dividend_i : '0;
                                w_state_nxt  = S_DONE;
                            end else begin
                                w_state_nxt  = S_DIVIDE;
                            end
                        end
                    end
                    S_DIVIDE: begin
                        w_p_nxt   = w_p_iter;
                        w_a_nxt   = {r_a[XLEN-2:0], ~w_p_iter[XLEN]};
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_cnt == c_last_iter) begin
                            w_state_nxt = S_RESTORE;
                        end
                    end
                    S_RESTORE: begin
                        w_p_nxt      = w_p_fix;
                        w_result_nxt = r_rem ? w_r_final : w_q_final;
                        w_state_nxt  = S_DONE;
                    end
                    S_DONE: begin
                        if (ready_i) begin
                            w_state_nxt = S_IDLE;
                            w_zdiv_nxt  = 1'b0;
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_p      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_rem    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_zdiv   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_p      <= w_p_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_result <= w_result_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rem    <= w_rem_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_zdiv   <= w_zdiv_nxt;
        end
    end

    assign ready_o       = (r_state == S_IDLE);
    assign valid_o       = (r_state == S_DONE);
    assign result_o      = r_result;
    assign zero_divide_o = r_zdiv;
    assign fu_state_o    = (r_state == S_IDLE) ? FREE : BUSY;

endmodule

`default_nettype wire

// File: tb/tb_div_unit_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit_pipe_ctrl
// Brief    : Directed self-checking bench for div_unit_pipe_ctrl (XLEN = 32).
// Revision : 1.0 - initial release
// ============================================================================

module tb_div_unit_pipe_ctrl;
    import div_unit_pipe_ctrl_pkg::*;

    localparam int XLEN = 32;
`ifdef DIV_EARLY_TERM_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = XLEN + 2;
`endif

    logic            clk = 1'b0;
    logic            rst, clk_en, kill, valid_in, ready_out, valid_out, ready_in, zdiv;
    logic [XLEN-1:0] dividend, divisor, result;
    div_ops_e        op;
    fu_state_e       fu;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    div_unit_pipe_ctrl #(.XLEN(XLEN)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clk_en_i     (clk_en),
        .kill_i       (kill),
        .valid_i      (valid_in),
        .ready_o      (ready_out),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .operation_i  (op),
        .valid_o      (valid_out),
        .ready_i      (ready_in),
        .result_o     (result),
        .zero_divide_o(zdiv),
        .fu_state_o   (fu)
    );

    // Issue one op, scramble the operand pins after accept, wait for valid_o,
    // then let the (ready_in = 1) handshake return the unit to IDLE.
    task automatic run_op(input div_ops_e o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          output int lat, output logic [XLEN-1:0] res, output logic zd);
        op = o; dividend = a; divisor = b; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0003; op = REMU_;
        lat = 1;
        while (!valid_out && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        zd  = zdiv;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_total++; if (ready_out !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready_out); else n_pass++;
        n_total++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_out); else n_pass++;
        n_total++; if (result !== '0) $display("FAIL reset_result: got %h expected 0", result); else n_pass++;
        n_total++; if (zdiv !== 1'b0) $display("FAIL reset_zdiv: got %b expected 0", zdiv); else n_pass++;
        n_total++; if (fu !== FREE) $display("FAIL reset_fu: got %0d expected FREE", fu); else n_pass++;
    endtask

    task automatic test_unsigned();
        int lat; logic [XLEN-1:0] res; logic zd;
        run_op(DIVU_, 32'd100, 32'd7, lat, res, zd);
        n_total++; if (lat !== 34) $display("FAIL divu_lat: got %0d expected 34", lat); else n_pass++;
        n_total++; if (res !== 32'd14) $display("FAIL divu_res: got %h expected %h", res, 32'd14); else n_pass++;
        n_total++; if (zd !== 1'b0) $display("FAIL divu_zdiv: got %b expected 0", zd); else n_pass++;
        run_op(REMU_, 32'd100, 32'd7, lat, res, zd);
        n_total++; if (res !== 32'd2) $display("FAIL remu_res: got %h expected %h", res, 32'd2); else n_pass++;
        run_op(REMU_, 32'd5, 32'd9, lat, res, zd);
        n_total++; if (lat !== LAT_SMALL) $display("FAIL remu_small_lat: got %0d expected %0d", lat, LAT_SMALL); else n_pass++;
        n_total++; if (res !== 32'd5) $display("FAIL remu_small_res: got %h expected %h", res, 32'd5); else n_pass++;
    endtask

    task automatic test_signed();
        int lat; logic [XLEN-1:0] res; logic zd;
        run_op(DIV_, 32'hFFFF_FF9C, 32'd7, lat, res, zd);
        n_total++; if (lat !== 34) $display("FAIL div_neg_lat: got %0d expected 34", lat); else n_pass++;
        n_total++; if (res !== 32'hFFFF_FFF2) $display("FAIL div_neg_res: got %h expected fffffff2", res); else n_pass++;
        run_op(REM_, 32'hFFFF_FF9C, 32'd7, lat, res, zd);
        n_total++; if (res !== 32'hFFFF_FFFE) $display("FAIL rem_neg_res: got %h expected fffffffe", res); else n_pass++;
        run_op(REM_, 32'd100, 32'hFFFF_FFF9, lat, res, zd);
        n_total++; if (res !== 32'd2) $display("FAIL rem_negdiv_res: got %h expected 00000002", res); else n_pass++;
        run_op(DIV_, 32'd100, 32'hFFFF_FFF9, lat, res, zd);
        n_total++; if (res !== 32'hFFFF_FFF2) $display("FAIL div_negdiv_res: got %h expected fffffff2", res); else n_pass++;
    endtask

    task automatic test_div_zero();
        int lat; logic [XLEN-1:0] res; logic zd;
        run_op(DIV_, 32'h0000_1234, 32'd0, lat, res, zd);
        n_total++; if (lat !== 1) $display("FAIL dz_div_lat: got %0d expected 1", lat); else n_pass++;
        n_total++; if (res !== 32'hFFFF_FFFF) $display("FAIL dz_div_res: got %h expected ffffffff", res); else n_pass++;
        n_total++; if (zd !== 1'b1) $display("FAIL dz_div_zdiv: got %b expected 1", zd); else n_pass++;
        run_op(REM_, 32'h0000_1234, 32'd0, lat, res, zd);
        n_total++; if (res !== 32'h0000_1234) $display("FAIL dz_rem_res: got %h expected 00001234", res); else n_pass++;
        n_total++; if (zd !== 1'b1) $display("FAIL dz_rem_zdiv: got %b expected 1", zd); else n_pass++;
    endtask

    task automatic test_overflow();
        int lat; logic [XLEN-1:0] res; logic zd;
        run_op(DIV_, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, zd);
        n_total++; if (lat !== 1) $display("FAIL ovf_div_lat: got %0d expected 1", lat); else n_pass++;
        n_total++; if (res !== 32'h8000_0000) $display("FAIL ovf_div_res: got %h expected 80000000", res); else n_pass++;
        n_total++; if (zd !== 1'b0) $display("FAIL ovf_div_zdiv: got %b expected 0", zd); else n_pass++;
        run_op(REM_, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, zd);
        n_total++; if (res !== 32'h0) $display("FAIL ovf_rem_res: got %h expected 00000000", res); else n_pass++;
        run_op(DIVU_, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, zd);
        n_total++; if (lat !== LAT_SMALL) $display("FAIL ovf_divu_lat: got %0d expected %0d", lat, LAT_SMALL); else n_pass++;
        n_total++; if (res !== 32'h0) $display("FAIL ovf_divu_res: got %h expected 00000000", res); else n_pass++;
        run_op(DIV_, 32'h8000_0000, 32'd2, lat, res, zd);
        n_total++; if (res !== 32'hC000_0000) $display("FAIL intmin_div2_res: got %h expected c0000000", res); else n_pass++;
    endtask

    task automatic test_backpressure();
        int wait_cnt = 0;
        ready_in = 1'b0;
        op = DIVU_; dividend = 32'd100; divisor = 32'd7; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        while (!valid_out && wait_cnt < 200) begin @(posedge clk); #1; wait_cnt++; end
        n_total++; if (valid_out !== 1'b1) $display("FAIL bp_reach_done: got %b expected 1", valid_out); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_total++; if (valid_out !== 1'b1) $display("FAIL bp_valid_hold: got %b expected 1", valid_out); else n_pass++;
            n_total++; if (result !== 32'd14) $display("FAIL bp_result_hold: got %h expected 0000000e", result); else n_pass++;
            n_total++; if (ready_out !== 1'b0) $display("FAIL bp_ready_low: got %b expected 0", ready_out); else n_pass++;
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        n_total++; if (ready_out !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", ready_out); else n_pass++;
        n_total++; if (valid_out !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", valid_out); else n_pass++;
    endtask

    task automatic test_clk_en();
        int lat;
        op = DIVU_; dividend = 32'd1000; divisor = 32'd3; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        lat = 1;
        repeat (9) begin @(posedge clk); #1; lat++; end
        clk_en = 1'b0;
        repeat (5) begin @(posedge clk); #1; lat++; end
        n_total++; if (ready_out !== 1'b0) $display("FAIL ce_frozen_busy: got %b expected 0", ready_out); else n_pass++;
        clk_en = 1'b1;
        while (!valid_out && lat < 200) begin @(posedge clk); #1; lat++; end
        n_total++; if (lat !== 39) $display("FAIL ce_lat: got %0d expected 39", lat); else n_pass++;
        n_total++; if (result !== 32'd333) $display("FAIL ce_res: got %h expected 0000014d", result); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_kill();
        logic saw_valid = 1'b0;
        op = DIVU_; dividend = 32'd100; divisor = 32'd7; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (12) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        n_total++; if (ready_out !== 1'b1) $display("FAIL kill_ready: got %b expected 1", ready_out); else n_pass++;
        n_total++; if (fu !== FREE) $display("FAIL kill_fu: got %0d expected FREE", fu); else n_pass++;
        n_total++; if (result !== 32'd333) $display("FAIL kill_result_kept: got %h expected 0000014d", result); else n_pass++;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_out) saw_valid = 1'b1;
        end
        n_total++; if (saw_valid !== 1'b0) $display("FAIL kill_no_valid: got %b expected 0", saw_valid); else n_pass++;
        op = DIV_; dividend = 32'd50; divisor = 32'd5; valid_in = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; kill = 1'b0;
        n_total++; if (ready_out !== 1'b1) $display("FAIL kill_blocks_accept: got %b expected 1", ready_out); else n_pass++;
    endtask

    task automatic test_reset_mid();
        op = DIVU_; dividend = 32'd100; divisor = 32'd7; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        n_total++; if (ready_out !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", ready_out); else n_pass++;
        n_total++; if (result !== '0) $display("FAIL rstmid_result: got %h expected 0", result); else n_pass++;
        n_total++; if (valid_out !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", valid_out); else n_pass++;
        n_total++; if (fu !== FREE) $display("FAIL rstmid_fu: got %0d expected FREE", fu); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat; logic [XLEN-1:0] res; logic zd;
        run_op(DIVU_, 32'd1000, 32'd10, lat, res, zd);
        n_total++; if (res !== 32'd100) $display("FAIL b2b_first_res: got %h expected 00000064", res); else n_pass++;
        n_total++; if (ready_out !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", ready_out); else n_pass++;
        run_op(DIV_, 32'hFFFF_FFF9, 32'd2, lat, res, zd);
        n_total++; if (lat !== 34) $display("FAIL b2b_second_lat: got %0d expected 34", lat); else n_pass++;
        n_total++; if (res !== 32'hFFFF_FFFD) $display("FAIL b2b_second_res: got %h expected fffffffd", res); else n_pass++;
        run_op(REM_, 32'hFFFF_FFF9, 32'd2, lat, res, zd);
        n_total++; if (res !== 32'hFFFF_FFFF) $display("FAIL b2b_third_res: got %h expected ffffffff", res); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; kill = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        dividend = '0; divisor = '0; op = DIVU_;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_clk_en();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
